// File: rtl/mul_accumulator.sv
// Group accumulator for the 8x{1,2,3,4} multiplier products, with ready/valid on both sides.
// Define MUL_ACC_SATURATE_EN to clamp the sum at 2^ACC_W-1 on overflow instead of wrapping.
module mul_accumulator #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [9:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             in_ready_q;
  logic             out_valid_q;

  logic             accept;
  logic             consume;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt_next;

  assign accept  = in_valid & in_ready_q;
  assign consume = out_valid_q & out_ready;

  always_comb begin
    sum_ext = {1'b0, acc} + {{(ACC_W + 1 - 10){1'b0}}, in_data};
    carry   = sum_ext[ACC_W];
`ifdef MUL_ACC_SATURATE_EN
    acc_next = carry ? '1 : sum_ext[ACC_W-1:0];
`else
    acc_next = sum_ext[ACC_W-1:0];
`endif
    cnt_next = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (accept) begin
            acc <= acc_next;
            cnt <= cnt_next;
            if (carry) ovf <= 1'b1;
            if (in_last) begin
              state       <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state <= ACC;
            end
          end
        end
        DONE: begin
          if (consume) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          acc         <= '0;
          cnt         <= '0;
          ovf         <= 1'b0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc;
  assign out_count = cnt;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_mul_accumulator.sv
// Directed bench for mul_accumulator: default-width instance plus a CNT_W=2 instance for counter saturation.
module tb_mul_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [9:0]  in_data = '0;
  logic        in_ready, out_valid, out_ovf;
  logic [15:0] out_sum;
  logic [7:0]  out_count;

  logic        in_valid2 = 1'b0, in_last2 = 1'b0, out_ready2 = 1'b0;
  logic [9:0]  in_data2 = '0;
  logic        in_ready2, out_valid2, out_ovf2;
  logic [15:0] out_sum2;
  logic [1:0]  out_count2;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  mul_accumulator #(.ACC_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  mul_accumulator #(.ACC_W(16), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_last(in_last2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_sum(out_sum2), .out_count(out_count2), .out_ovf(out_ovf2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [9:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    int unsigned exp_wrap;
`ifdef MUL_ACC_SATURATE_EN
    exp_wrap = 65535;
`else
    exp_wrap = 764;
`endif

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_sum", 32'(out_sum), 32'd0);
    check("rst_count", 32'(out_count), 32'd0);
    check("rst_ovf", 32'(out_ovf), 32'd0);

    // Single-beat group, consumer always ready
    out_ready = 1'b1;
    beat(10'd1020, 1'b1);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_sum", 32'(out_sum), 32'd1020);
    check("single_count", 32'(out_count), 32'd1);
    check("single_ovf", 32'(out_ovf), 32'd0);
    check("single_ready0", 32'(in_ready), 32'd0);
    step();
    check("single_idle_valid", 32'(out_valid), 32'd0);
    check("single_idle_ready", 32'(in_ready), 32'd1);
    check("single_idle_sum", 32'(out_sum), 32'd0);

    // Three beats with gaps, then back-pressure in DONE
    out_ready = 1'b0;
    beat(10'd5, 1'b0);
    step();
    step();
    check("gap_sum_hold", 32'(out_sum), 32'd5);
    check("gap_count_hold", 32'(out_count), 32'd1);
    beat(10'd10, 1'b0);
    step();
    beat(10'd765, 1'b1);
    check("grp3_valid", 32'(out_valid), 32'd1);
    check("grp3_sum", 32'(out_sum), 32'd780);
    check("grp3_count", 32'(out_count), 32'd3);
    check("grp3_ready0", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 10'd50;
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_sum", 32'(out_sum), 32'd780);
      check("bp_count", 32'(out_count), 32'd3);
      check("bp_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_consumed", 32'(out_valid), 32'd0);
    check("bp_cleared", 32'(out_count), 32'd0);

    // 65 beats of 1020 overflow a 16-bit sum on the last one
    for (int i = 0; i < 65; i++) begin
      beat(10'd1020, (i == 64));
      if (i == 63) begin
        check("ovf_pre_sum", 32'(out_sum), 32'd65280);
        check("ovf_pre_flag", 32'(out_ovf), 32'd0);
      end
    end
    check("ovf_valid", 32'(out_valid), 32'd1);
    check("ovf_flag", 32'(out_ovf), 32'd1);
    check("ovf_count", 32'(out_count), 32'd65);
    check("ovf_sum", 32'(out_sum), exp_wrap);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("ovf_cleared", 32'(out_ovf), 32'd0);

    // Reset mid-group discards the partial result
    beat(10'd100, 1'b0);
    beat(10'd100, 1'b0);
    check("mid_sum", 32'(out_sum), 32'd200);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_sum", 32'(out_sum), 32'd0);
    check("midrst_count", 32'(out_count), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    beat(10'd7, 1'b1);
    check("after_rst_valid", 32'(out_valid), 32'd1);
    check("after_rst_sum", 32'(out_sum), 32'd7);
    check("after_rst_count", 32'(out_count), 32'd1);

    // Reset while holding a result in DONE
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("donerst_valid", 32'(out_valid), 32'd0);
    check("donerst_sum", 32'(out_sum), 32'd0);
    check("donerst_ready", 32'(in_ready), 32'd1);

    // Counter saturation on the CNT_W=2 instance
    for (int i = 0; i < 6; i++) begin
      in_valid2 = 1'b1;
      in_data2  = 10'd1;
      in_last2  = (i == 5);
      step();
      if (i == 3) check("c2_sat_early", 32'(out_count2), 32'd3);
    end
    in_valid2 = 1'b0;
    in_last2  = 1'b0;
    check("c2_valid", 32'(out_valid2), 32'd1);
    check("c2_count", 32'(out_count2), 32'd3);
    check("c2_sum", 32'(out_sum2), 32'd6);
    check("c2_ovf", 32'(out_ovf2), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
